// File: rtl/branch_predictor_bht_pkg.sv
// Shared types and constants for the branch history table.
// Counter encoding, default index width and the table entry layout.
package branch_predictor_bht_pkg;

    localparam int IDX_W_DEFAULT = 6;

    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    // Tag is sized for the narrowest index; unused upper bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } bht_entry_t;

endpackage

// File: rtl/branch_predictor_bht_sat_ctr.sv
// 2-bit saturating counter next-state function.
// Taken steps toward strong-taken, not-taken toward strong-not-taken.
module bht_sat_ctr
    import branch_predictor_bht_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (1'b1)
            taken && (ctr != CTR_ST):  ctr_next = ctr + 2'd1;
            !taken && (ctr != CTR_SN): ctr_next = ctr - 2'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with EX-stage training and redirect.
// Define BHT_STATS_EN to add branch / mispredict event counters.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int         IDX_W     = IDX_W_DEFAULT,
    parameter logic [1:0] RESET_CTR = CTR_WN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BHT_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int DEPTH = 2 ** IDX_W;

    function automatic logic [29:0] tag_of(input logic [31:0] pc);
        return 30'(pc[31:IDX_W+2]);
    endfunction

    bht_entry_t bht_q [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    bht_entry_t       if_ent;
    bht_entry_t       upd_ent;
    logic             if_hit;
    logic             upd_hit;
    logic [1:0]       ctr_next;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign if_ent  = bht_q[if_idx];
    assign upd_ent = bht_q[upd_idx];
    assign if_hit  = if_ent.valid && (if_ent.tag == tag_of(if_pc));
    assign upd_hit = upd_ent.valid && (upd_ent.tag == tag_of(upd_pc));

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = if_pc + 32'd4;
        if (!rst && if_hit && if_ent.ctr[1]) begin
            pred_taken  = 1'b1;
            pred_target = if_ent.target;
        end
    end

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (upd_valid && !rst) begin
            mispredict  = (upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target));
            redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
        end
    end

    bht_sat_ctr u_sat_ctr (
        .ctr      (upd_ent.ctr),
        .taken    (upd_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                              ctr: RESET_CTR};
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                bht_q[upd_idx].ctr <= ctr_next;
                if (upd_taken) begin
                    bht_q[upd_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                // Only taken branches earn a slot; not-taken misses are free.
                bht_q[upd_idx] <= '{valid: 1'b1, tag: tag_of(upd_pc),
                                    target: upd_target, ctr: CTR_WT};
            end
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht.
// Directed vector table, reset corner cases, then randomized vs. a model.
module tb_branch_predictor_bht;

    localparam int IDX_W = 6;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BHT_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor_bht #(.IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BHT_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        logic [31:0] ipc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        upt;
        logic [31:0] uptg;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_mp;
        logic [31:0] e_rd;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference table: plain arrays, counter held as an integer 0..3.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    int unsigned exp_br = 0;
    int unsigned exp_mp = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        exp_br = 0;
        exp_mp = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int          idx;
        int unsigned tag;
        idx = int'((pc >> 2) % DEPTH);
        tag = pc >> (IDX_W + 2);
        return m_valid[idx] && (m_tag[idx] == tag);
    endfunction

    function automatic void model_lookup(input logic [31:0] pc,
                                         output logic pt,
                                         output logic [31:0] tgt);
        int idx;
        idx = int'((pc >> 2) % DEPTH);
        pt  = model_hit(pc) && (m_ctr[idx] >= 2);
        tgt = pt ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [31:0] pc,
                                         input logic taken,
                                         input logic [31:0] tgt);
        int idx;
        idx = int'((pc >> 2) % DEPTH);
        if (model_hit(pc)) begin
            if (taken) begin
                m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                m_tgt[idx] = tgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            end
        end else if (taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc >> (IDX_W + 2);
            m_tgt[idx]   = tgt;
            m_ctr[idx]   = 2;
        end
    endfunction

    function automatic vec_t mk(
        input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
        input logic ut, input logic [31:0] utg, input logic upt,
        input logic [31:0] uptg, input logic e_pt, input logic [31:0] e_ptg,
        input logic e_mp, input logic [31:0] e_rd);
        vec_t v;
        v.ipc = ipc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
        v.upt = upt; v.uptg = uptg; v.e_pt = e_pt; v.e_ptg = e_ptg;
        v.e_mp = e_mp; v.e_rd = e_rd;
        return v;
    endfunction

    // Expected outputs straight from the model (pre-edge table contents).
    function automatic vec_t model_vec(vec_t v);
        vec_t r;
        r = v;
        model_lookup(v.ipc, r.e_pt, r.e_ptg);
        r.e_mp = 1'b0;
        r.e_rd = '0;
        if (v.uv) begin
            r.e_mp = (v.ut != v.upt) || (v.ut && (v.utg != v.uptg));
            r.e_rd = v.ut ? v.utg : v.upc + 32'd4;
        end
        return r;
    endfunction

    task automatic run_cycle(input vec_t v, input string name);
        if_pc           = v.ipc;
        upd_valid       = v.uv;
        upd_pc          = v.upc;
        upd_taken       = v.ut;
        upd_target      = v.utg;
        upd_pred_taken  = v.upt;
        upd_pred_target = v.uptg;
        #1;
        chk({name, ".pred_taken"}, 32'(pred_taken), 32'(v.e_pt));
        chk({name, ".pred_target"}, pred_target, v.e_ptg);
        chk({name, ".mispredict"}, 32'(mispredict), 32'(v.e_mp));
        chk({name, ".redirect_pc"}, redirect_pc, v.e_rd);
        @(posedge clk);
        if (v.uv) begin
            exp_br++;
            if (v.e_mp) exp_mp++;
            model_update(v.upc, v.ut, v.utg);
        end
        @(negedge clk);
    endtask

    task automatic chk_stats(input string name);
`ifdef BHT_STATS_EN
        chk({name, ".stat_branches"}, stat_branches, exp_br);
        chk({name, ".stat_mispredicts"}, stat_mispredicts, exp_mp);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    vec_t tbl [17];

    initial begin
        logic [31:0] tags [4];
        vec_t        v;

        model_clear();
        tbl[0]  = mk(32'h100, 0, 0, 0, 0, 0, 0,
                     0, 32'h104, 0, 0);
        tbl[1]  = mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
                     0, 32'h104, 1, 32'h80);
        tbl[2]  = mk(32'h100, 0, 0, 0, 0, 0, 0,
                     1, 32'h80, 0, 0);
        tbl[3]  = mk(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
                     1, 32'h80, 0, 32'h80);
        tbl[4]  = mk(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
                     1, 32'h80, 0, 32'h80);
        tbl[5]  = mk(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,
                     1, 32'h80, 1, 32'h104);
        tbl[6]  = mk(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80,
                     1, 32'h80, 1, 32'h104);
        tbl[7]  = mk(32'h100, 0, 0, 0, 0, 0, 0,
                     0, 32'h104, 0, 0);
        tbl[8]  = mk(32'h100, 1, 32'h200, 1, 32'h240, 0, 32'h204,
                     0, 32'h104, 1, 32'h240);
        tbl[9]  = mk(32'h100, 0, 0, 0, 0, 0, 0,
                     0, 32'h104, 0, 0);
        tbl[10] = mk(32'h200, 0, 0, 0, 0, 0, 0,
                     1, 32'h240, 0, 0);
        tbl[11] = mk(32'h300, 1, 32'h300, 0, 32'h9000, 0, 32'h304,
                     0, 32'h304, 0, 32'h304);
        tbl[12] = mk(32'h300, 0, 0, 0, 0, 0, 0,
                     0, 32'h304, 0, 0);
        tbl[13] = mk(32'h200, 0, 0, 0, 0, 0, 0,
                     1, 32'h240, 0, 0);
        tbl[14] = mk(32'h200, 1, 32'h200, 1, 32'h500, 1, 32'h240,
                     1, 32'h240, 1, 32'h500);
        tbl[15] = mk(32'h200, 0, 0, 0, 0, 0, 0,
                     1, 32'h500, 0, 0);
        tbl[16] = mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h10, 0, 32'h0,
                     0, 32'h0, 0, 32'h0);

        // Outputs while reset is held, with an update presented.
        if_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        upd_target = 32'h80; upd_pred_taken = 1'b0;
        upd_pred_target = 32'h104;
        #3;
        chk("rst.pred_taken", 32'(pred_taken), 32'd0);
        chk("rst.pred_target", pred_target, 32'h104);
        chk("rst.mispredict", 32'(mispredict), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_stats("rst");
        upd_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_cycle(tbl[i], $sformatf("tbl%0d", i));
        end
        chk_stats("after_tbl");

        // Reset asserted mid-cycle with an allocating update pending.
        v = mk(32'h200, 1, 32'h400, 1, 32'h700, 0, 32'h404,
               0, 0, 0, 0);
        if_pc = v.ipc; upd_valid = v.uv; upd_pc = v.upc;
        upd_taken = v.ut; upd_target = v.utg;
        upd_pred_taken = v.upt; upd_pred_target = v.uptg;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.pred_taken", 32'(pred_taken), 32'd0);
        chk("midrst.pred_target", pred_target, 32'h204);
        chk("midrst.mispredict", 32'(mispredict), 32'd0);
        @(posedge clk);
        @(negedge clk);
        model_clear();
        chk_stats("midrst");
        rst = 1'b0;
        run_cycle(mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 32'h204, 0, 0),
                  "post_rst_200");
        run_cycle(mk(32'h400, 0, 0, 0, 0, 0, 0, 0, 32'h404, 0, 0),
                  "post_rst_400");
        run_cycle(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0),
                  "post_rst_100");

        // Randomized traffic over a small PC pool to force hits and aliasing.
        tags[0] = 32'h1000; tags[1] = 32'h2000;
        tags[2] = 32'h3000; tags[3] = 32'h8000_0000;
        for (int n = 0; n < 400; n++) begin
            v.upc = tags[$urandom_range(0, 3)] |
                    32'($urandom_range(0, 7) << 2) |
                    32'($urandom_range(0, 3));
            v.ipc = ($urandom_range(0, 3) == 0) ? v.upc :
                    (tags[$urandom_range(0, 3)] |
                     32'($urandom_range(0, 7) << 2));
            v.uv  = ($urandom_range(0, 3) != 0);
            v.ut  = 1'($urandom_range(0, 1));
            v.utg = ($urandom_range(0, 1) == 0) ? 32'h4000 : $urandom;
            if ($urandom_range(0, 1) == 0) begin
                model_lookup(v.upc, v.upt, v.uptg);
            end else begin
                v.upt  = 1'($urandom_range(0, 1));
                v.uptg = v.upt ? 32'h4000 : v.upc + 32'd4;
            end
            v = model_vec(v);
            run_cycle(v, $sformatf("rnd%0d", n));
        end
        chk_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Front-end partner of the EX-stage branch comparator: predicts in IF the branch outcome that the comparator later resolves in EX.
- Direct-mapped table; each entry holds a valid bit, tag, target and 2-bit saturating counter.
- IF issues a combinational lookup each cycle. EX returns the resolved outcome (comparator output) plus what was predicted. The block trains the table and flags mispredictions for pipeline redirect.

Parameters:
- IDX_W, 6, index bits; table depth = 2**IDX_W entries
- RESET_CTR, 2'b01, counter value loaded into every entry at reset (weakly not-taken)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- if_pc  input  32  fetch PC to look up
- pred_taken  output  1  prediction for if_pc
- pred_target  output  32  predicted next PC for if_pc
- upd_valid  input  1  EX holds a resolved conditional branch this cycle
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual outcome (comparator result)
- upd_target  input  32  actual branch target (pc+imm)
- upd_pred_taken  input  1  prediction that travelled with this branch
- upd_pred_target  input  32  predicted next PC that travelled with this branch
- mispredict  output  1  EX must flush IF/ID and redirect
- redirect_pc  output  32  correct next PC when mispredict=1

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Reset (asynchronous): all entries cleared to valid=0, tag=0, target=0, counter=RESET_CTR.
  - pred_taken=0 and pred_target=if_pc+4 while rst is high.
  - mispredict=0 while rst is high.
- Lookup (combinational, zero latency): hit = valid[idx] && tag[idx]==tag(if_pc).
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4 (32-bit wrap).
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken increments, saturating at 11.
  - Not-taken decrements, saturating at 00.
- Update (clk rising edge, only when upd_valid=1 and rst=0):
  - Hit: counter steps as above. On a taken branch, target is overwritten with upd_target.
  - Miss, taken: allocate/replace the entry with valid=1, tag=tag(upd_pc), target=upd_target, counter=10.
  - Miss, not-taken: table unchanged (no allocation).
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new value is visible the next cycle.
- Mispredict (combinational, valid only when upd_valid=1):
  - mispredict = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - When upd_valid=0: mispredict=0, redirect_pc=0.
- Reset asserted mid-operation: table contents are lost immediately. Any update on that edge is dropped.
- Non-branch instructions never drive upd_valid. Jumps are out of scope.

Optional Feature:
- Macro: BHT_STATS_EN
- With the macro:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Both reset to 0.
  - stat_branches +1 on every clock edge with upd_valid=1.
  - stat_mispredicts +1 when upd_valid=1 and mispredict=1.
  - Both counters wrap at 2**32.
- Without the macro: the ports and the counters do not exist. Prediction and update behaviour is identical.

Decomposition:
- Shared package:
  - Counter-state constants CTR_SN/CTR_WN/CTR_WT/CTR_ST.
  - Default IDX_W.
  - An entry struct typedef {valid, tag, target, ctr}.
- One natural sub-module: bht_sat_ctr, the 2-bit saturating next-state function (inputs ctr and taken; output next ctr), instanced once on the update path.

Test Plan:
1. Reset, then lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104.
2. Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle, lookup 0x100 -> pred_taken=1, pred_target=0x80.
3. Three taken updates at 0x100, then two not-taken updates -> counter 10→11→11→10→01. Final lookup pred_taken=0.
4. Aliasing: with IDX_W=6, taken update at 0x100, then taken update at 0x200 (same index, different tag) -> entry replaced. Lookup 0x100 misses (pred_target=0x104); lookup 0x200 predicts 0x80's new target.
5. Not-taken update at never-seen 0x300 with pred_taken=0 -> mispredict=0 and no allocation. Lookup 0x300 still misses.
6. Same-cycle lookup and update on index 0x100 -> lookup shows old value. Assert rst mid-sequence -> all lookups miss. With BHT_STATS_EN, counts equal the scoreboard values.
